// File: rtl/taxi_qsfp_port_mgr.sv
// taxi_qsfp_port_mgr: per-cage QSFP presence debounce, reset/init sequencing and interrupt latching
module taxi_qsfp_port_mgr #(
  parameter int PORTS           = 9,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int RESET_CYCLES    = 1250,
  parameter int INIT_CYCLES     = 250000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] port_modprsl,
  input  logic [PORTS-1:0] port_intl,
  output logic [PORTS-1:0] port_resetl,
  input  logic [PORTS-1:0] reset_req,
  input  logic [PORTS-1:0] int_clear,
  output logic [PORTS-1:0] port_present,
  output logic [PORTS-1:0] port_ready,
  output logic [PORTS-1:0] port_int,
  output logic [PORTS-1:0] status_change
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM = (RESET_CYCLES > INIT_CYCLES) ? RESET_CYCLES : INIT_CYCLES;
  localparam int TW = (TM > 1) ? $clog2(TM) : 1;
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] RST_END  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] INIT_END = TW'(INIT_CYCLES - 1);
  typedef enum logic [1:0] {ABSENT, RESET, INIT, READY} state_e;
  logic [PORTS-1:0] prs_s1_q, prs_s2_q, int_s1_q, int_s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      prs_s1_q <= '1;
      prs_s2_q <= '1;
      int_s1_q <= '1;
      int_s2_q <= '1;
    end else begin
      prs_s1_q <= port_modprsl;
      prs_s2_q <= prs_s1_q;
      int_s1_q <= port_intl;
      int_s2_q <= int_s1_q;
    end
  end
  for (genvar i = 0; i < PORTS; i++) begin : g_port
    logic [DW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    state_e        st_q, st_d;
    logic          pres_q, pres_d, int_q, int_d, rdy_q, rstl_q, sc_q;
    always_comb begin
      // stability is judged on the sample entering the last sync stage
      cnt_d  = (prs_s1_q[i] != prs_s2_q[i]) ? '0 : (cnt_q == DB_MAX) ? cnt_q : cnt_q + 1'b1;
      pres_d = (cnt_q == DB_MAX) ? ~prs_s2_q[i] : pres_q;
      st_d   = st_q;
      tmr_d  = tmr_q + 1'b1;
      if (!pres_q) begin
        st_d  = ABSENT;
        tmr_d = '0;
      end else if (reset_req[i] && st_q != ABSENT) begin
        st_d  = RESET;
        tmr_d = '0;
      end else begin
        case (st_q)
          ABSENT: begin
            st_d  = RESET;
            tmr_d = '0;
          end
          RESET: if (tmr_q == RST_END) begin
            st_d  = INIT;
            tmr_d = '0;
          end
          INIT: if (tmr_q == INIT_END) begin
            st_d  = READY;
            tmr_d = '0;
          end
          default: tmr_d = '0;
        endcase
      end
      int_d = (st_d == ABSENT) ? 1'b0 :
              (st_q == READY && !int_s2_q[i]) ? 1'b1 :
              int_clear[i] ? 1'b0 : int_q;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        tmr_q  <= '0;
        st_q   <= ABSENT;
        pres_q <= 1'b0;
        int_q  <= 1'b0;
        rdy_q  <= 1'b0;
        rstl_q <= 1'b0;
        sc_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        tmr_q  <= tmr_d;
        st_q   <= st_d;
        pres_q <= pres_d;
        int_q  <= int_d;
        rdy_q  <= (st_d == READY);
        rstl_q <= (st_d == INIT) || (st_d == READY);
        sc_q   <= (pres_d != pres_q) || ((st_d == READY) != rdy_q);
      end
    end
    assign port_present[i]  = pres_q;
    assign port_ready[i]    = rdy_q;
    assign port_resetl[i]   = rstl_q;
    assign port_int[i]      = int_q;
    assign status_change[i] = sc_q;
  end
endmodule

// File: tb/tb_taxi_qsfp_port_mgr.sv
// tb_taxi_qsfp_port_mgr: directed insertion/glitch/reset/interrupt/removal sequence with a cycle-stamped expectation queue
module tb_taxi_qsfp_port_mgr;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] port_modprsl = 2'b11;
  logic [1:0] port_intl = 2'b11;
  logic [1:0] reset_req = 2'b00;
  logic [1:0] int_clear = 2'b00;
  logic [1:0] port_resetl, port_present, port_ready, port_int, status_change;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    int    c;
    int    s;
    int    p;
    logic  v;
    string t;
  } exp_t;
  exp_t q[$];
  taxi_qsfp_port_mgr #(
    .PORTS(2), .DEBOUNCE_CYCLES(4), .RESET_CYCLES(8), .INIT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .port_modprsl(port_modprsl), .port_intl(port_intl),
    .port_resetl(port_resetl), .reset_req(reset_req), .int_clear(int_clear),
    .port_present(port_present), .port_ready(port_ready), .port_int(port_int),
    .status_change(status_change)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic obs(input int s, input int p);
    return s == 0 ? port_present[p] : s == 1 ? port_ready[p] : s == 2 ? port_resetl[p] :
           s == 3 ? port_int[p] : status_change[p];
  endfunction
  function automatic string sname(input int s);
    return s == 0 ? "present" : s == 1 ? "ready" : s == 2 ? "resetl" : s == 3 ? "int" : "status_change";
  endfunction
  always @(negedge clk) begin
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].c == cyc) begin
        checks++;
        assert (obs(q[k].s, q[k].p) === q[k].v) else begin
          failures++;
          $error("FAIL %s cyc=%0d %s[%0d] got=%b exp=%b", q[k].t, cyc, sname(q[k].s), q[k].p,
                 obs(q[k].s, q[k].p), q[k].v);
        end
        q.delete(k);
      end
    end
  end
  task automatic ex(input int c, input int s, input int p, input logic v, input string t);
    q.push_back('{c, s, p, v, t});
  endtask
  task automatic exr(input int c0, input int c1, input int s, input int p, input logic v, input string t);
    for (int c = c0; c <= c1; c++) ex(c, s, p, v, t);
  endtask
  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 5; s++) ex(2, s, p, 1'b0, "reset_val");
    at(2);
    rst = 1'b0;
    at(10);
    ex(16, 0, 0, 1'b0, "ins_pres_early");
    ex(17, 0, 0, 1'b1, "ins_pres");
    ex(16, 4, 0, 1'b0, "ins_sc_early");
    ex(17, 4, 0, 1'b1, "ins_sc");
    ex(18, 4, 0, 1'b0, "ins_sc_end");
    exr(17, 25, 2, 0, 1'b0, "ins_resetl_low");
    exr(26, 41, 2, 0, 1'b1, "ins_resetl_high");
    ex(41, 1, 0, 1'b0, "ins_ready_early");
    ex(42, 1, 0, 1'b1, "ins_ready");
    ex(41, 4, 0, 1'b0, "rdy_sc_early");
    ex(42, 4, 0, 1'b1, "rdy_sc");
    ex(43, 4, 0, 1'b0, "rdy_sc_end");
    ex(17, 0, 1, 1'b0, "p1_pres");
    ex(42, 0, 1, 1'b0, "p1_pres");
    ex(42, 2, 1, 1'b0, "p1_resetl");
    port_modprsl[0] = 1'b0;
    at(12);
    ex(20, 0, 1, 1'b0, "glitch_pres");
    ex(25, 0, 1, 1'b0, "glitch_pres");
    ex(30, 0, 1, 1'b0, "glitch_pres");
    exr(12, 30, 4, 1, 1'b0, "glitch_sc");
    ex(25, 2, 1, 1'b0, "glitch_resetl");
    port_modprsl[1] = 1'b0;
    at(15);
    port_modprsl[1] = 1'b1;
    at(28);
    ex(31, 3, 0, 1'b0, "init_int");
    ex(34, 3, 0, 1'b0, "init_int");
    ex(37, 3, 0, 1'b0, "init_int");
    port_intl[0] = 1'b0;
    at(34);
    port_intl[0] = 1'b1;
    at(45);
    ex(47, 3, 0, 1'b0, "rdy_int_early");
    ex(48, 3, 0, 1'b1, "rdy_int_set");
    port_intl[0] = 1'b0;
    at(50);
    ex(51, 3, 0, 1'b1, "clr_vs_set");
    ex(52, 3, 0, 1'b1, "clr_vs_set");
    int_clear[0] = 1'b1;
    at(51);
    int_clear[0] = 1'b0;
    at(53);
    ex(57, 3, 0, 1'b1, "int_sticky");
    port_intl[0] = 1'b1;
    at(58);
    ex(58, 3, 0, 1'b1, "int_pre_clr");
    ex(59, 3, 0, 1'b0, "int_clr");
    ex(60, 3, 0, 1'b0, "int_clr");
    int_clear[0] = 1'b1;
    at(59);
    int_clear[0] = 1'b0;
    at(62);
    ex(65, 3, 0, 1'b1, "int_rearm");
    port_intl[0] = 1'b0;
    at(64);
    port_intl[0] = 1'b1;
    at(70);
    ex(70, 1, 0, 1'b1, "sw_ready_pre");
    ex(71, 1, 0, 1'b0, "sw_ready_drop");
    ex(71, 4, 0, 1'b1, "sw_sc");
    exr(72, 97, 4, 0, 1'b0, "sw_sc_quiet");
    ex(70, 2, 0, 1'b1, "sw_resetl_pre");
    exr(71, 81, 2, 0, 1'b0, "sw_resetl_low");
    ex(82, 2, 0, 1'b1, "sw_resetl_rel");
    ex(97, 1, 0, 1'b0, "sw_ready_early");
    ex(98, 1, 0, 1'b1, "sw_ready");
    ex(98, 4, 0, 1'b1, "sw_ready_sc");
    reset_req[0] = 1'b1;
    at(71);
    reset_req[0] = 1'b0;
    at(73);
    reset_req[0] = 1'b1;
    at(74);
    reset_req[0] = 1'b0;
    at(100);
    reset_req[0] = 1'b1;
    at(101);
    reset_req[0] = 1'b0;
    at(112);
    ex(118, 0, 0, 1'b1, "rm_pres_early");
    ex(119, 0, 0, 1'b0, "rm_pres");
    ex(119, 4, 0, 1'b1, "rm_sc");
    exr(120, 124, 4, 0, 1'b0, "rm_sc_single");
    ex(119, 2, 0, 1'b1, "rm_resetl_init");
    ex(120, 2, 0, 1'b0, "rm_resetl");
    ex(119, 3, 0, 1'b1, "rm_int_held");
    ex(120, 3, 0, 1'b0, "rm_int_cleared");
    ex(120, 1, 0, 1'b0, "rm_ready");
    port_modprsl[0] = 1'b1;
    at(118);
    ex(125, 0, 0, 1'b1, "reins_pres");
    ex(125, 4, 0, 1'b1, "reins_sc");
    port_modprsl[0] = 1'b0;
    at(152);
    ex(152, 1, 0, 1'b1, "pre_rst_ready");
    at(155);
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 5; s++) ex(156, s, p, 1'b0, "midrst_val");
    ex(162, 0, 0, 1'b0, "rerun_pres_early");
    ex(163, 0, 0, 1'b1, "rerun_pres");
    ex(163, 4, 0, 1'b1, "rerun_sc");
    ex(171, 2, 0, 1'b0, "rerun_resetl_low");
    ex(172, 2, 0, 1'b1, "rerun_resetl_rel");
    ex(187, 1, 0, 1'b0, "rerun_ready_early");
    ex(188, 1, 0, 1'b1, "rerun_ready");
    rst = 1'b1;
    at(156);
    rst = 1'b0;
    at(192);
    checks++;
    if (port_ready[0] !== 1'b1) begin
      failures++;
      $error("FAIL final_ready0 got=%b", port_ready[0]);
    end
    checks++;
    if (port_resetl[0] !== 1'b1) begin
      failures++;
      $error("FAIL final_resetl0 got=%b", port_resetl[0]);
    end
    checks++;
    if (port_present[0] !== 1'b1) begin
      failures++;
      $error("FAIL final_present0 got=%b", port_present[0]);
    end
    checks++;
    if (port_int[0] !== 1'b0) begin
      failures++;
      $error("FAIL final_int0 got=%b", port_int[0]);
    end
    checks++;
    if (status_change[0] !== 1'b0) begin
      failures++;
      $error("FAIL final_sc0 got=%b", status_change[0]);
    end
    checks++;
    if (port_present[1] !== 1'b0) begin
      failures++;
      $error("FAIL final_present1 got=%b", port_present[1]);
    end
    checks++;
    if (port_ready[1] !== 1'b0) begin
      failures++;
      $error("FAIL final_ready1 got=%b", port_ready[1]);
    end
    checks++;
    if (port_resetl[1] !== 1'b0) begin
      failures++;
      $error("FAIL final_resetl1 got=%b", port_resetl[1]);
    end
    foreach (q[k]) begin
      checks++;
      failures++;
      $error("FAIL unchecked_%s cyc=%0d got=none exp=%b", q[k].t, q[k].c, q[k].v);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
